ahb_lite_sram_slave: RTL

- Synthesizable AHB-Lite slave: byte-addressable SRAM model with configurable wait states and a two-cycle ERROR response.
- Sits directly downstream of the AHB bus interface. It consumes the master's address/control/write-data pins and produces HREADYOUT/HRESP/HRDATA.
- Serves as the reference DUT for the AHB master agent and the protocol assertions.

---
 rtl/ahb_lite_sram_slave.sv | 108 ++++++++++
 1 files changed

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite byte-addressable SRAM slave with programmable wait states
// and a two-cycle ERROR response for oversized, misaligned or out-of-range transfers.
module ahb_lite_sram_slave #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_STATES = 0,
    parameter int HRESP_W     = 2
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HSEL,
    input  logic [ADDR_W-1:0]  HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [2:0]         HBURST,
    input  logic [3:0]         HPROT,
    input  logic [DATA_W-1:0]  HWDATA,
    input  logic               HREADY,
    output logic               HREADYOUT,
    output logic [HRESP_W-1:0] HRESP,
    output logic [DATA_W-1:0]  HRDATA
);
    localparam int NB  = DATA_W / 8;
    localparam int LSZ = $clog2(NB);
    localparam int MW  = $clog2(MEM_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [MW-1:0]     a_addr, base, off;
    logic [2:0]        a_size;
    logic              a_write, a_valid;
    logic              accept, err, ready;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] word;
    logic [7:0]        mem [MEM_BYTES];
    logic              unused_ok;

    assign accept = HSEL & HREADY & HTRANS[1];
    assign err    = (HSIZE > 3'(LSZ))
                  | ((HADDR & ((ADDR_W'(1) << HSIZE) - ADDR_W'(1))) != '0)
                  | ({1'b0, HADDR} >= (ADDR_W + 1)'(MEM_BYTES));
    assign ready  = (state != S_WAIT) && (state != S_ERR1);
    assign base   = a_addr & ~MW'(NB - 1);
    assign off    = a_addr & MW'(NB - 1);
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_WAIT: begin
                cnt_nx   = cnt - 4'd1;
                state_nx = (cnt == 4'd1) ? S_IDLE : S_WAIT;
            end
            S_ERR1: state_nx = S_ERR2;
            default: begin
                state_nx = !accept ? S_IDLE : err ? S_ERR1 : (WAIT_STATES > 0) ? S_WAIT : S_IDLE;
                cnt_nx   = (accept && !err) ? 4'(WAIT_STATES) : 4'd0;
            end
        endcase
    end

    // A lane belongs to the transfer when it falls in the same size-aligned group as the address.
    always_comb begin
        be   = '0;
        word = '0;
        for (int b = 0; b < NB; b++) begin
            be[b]        = (MW'(b) >> a_size) == (off >> a_size);
            word[8*b+:8] = mem[base + MW'(b)];
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= S_IDLE;
            cnt     <= '0;
            a_addr  <= '0;
            a_size  <= '0;
            a_write <= 1'b0;
            a_valid <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (ready) begin
                a_valid <= accept & ~err;
                if (accept) begin
                    a_addr  <= HADDR[MW-1:0];
                    a_write <= HWRITE;
                    a_size  <= HSIZE;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (ready && a_valid && a_write)
            for (int b = 0; b < NB; b++)
                if (be[b]) mem[base + MW'(b)] <= HWDATA[8*b+:8];
    end

    assign HREADYOUT = ready;
    assign HRESP     = HRESP_W'(state == S_ERR1 || state == S_ERR2);
    assign HRDATA    = (a_valid && !a_write) ? word : '0;
endmodule
